// File: rtl/fini_fault_response_if.sv
// ---------------------------------------------------------------------------
// fini_fault_response_if : handshake/data bundle for the fault-response stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fini_fault_response_if #(
   parameter int WIDTH  = 1,
   parameter int COPIES = 3
);
   logic [COPIES*WIDTH-1:0] port_c;
   logic                    port_ok;
   logic                    port_valid_in;
   logic                    port_ready;
   logic [COPIES*WIDTH-1:0] port_d;
   logic                    port_valid_out;
   logic                    port_ready_out;
   logic                    port_fault;
   logic                    port_alarm;
   logic [3:0]              port_fault_cnt;

   modport master (
      output port_c, port_ok, port_valid_in, port_ready_out,
      input  port_ready, port_d, port_valid_out, port_fault, port_alarm, port_fault_cnt
   );

   modport slave (
      input  port_c, port_ok, port_valid_in, port_ready_out,
      output port_ready, port_d, port_valid_out, port_fault, port_alarm, port_fault_cnt
   );
endinterface

`default_nettype wire

// File: rtl/fini_fault_response.sv
// ---------------------------------------------------------------------------
// fini_fault_response : re-checks redundant product copies, zeroes faulty beats,
// counts faults and latches a sticky alarm.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fini_fault_response #(
   parameter int WIDTH     = 1,
   parameter int COPIES    = 3,
   parameter int THRESHOLD = 1
) (
   input  wire logic            port_clk,
   input  wire logic            port_rst,
   fini_fault_response_if.slave bus
);
   localparam int         DW  = COPIES * WIDTH;
   localparam logic [3:0] THR = 4'(THRESHOLD);

   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_ALARM = 1'b1} state_t;

   state_t          state_q;
   logic [DW-1:0]   data_q;
   logic            valid_q;
   logic            fault_q;
   logic [3:0]      cnt_q;
   logic [3:0]      cnt_d;
   logic            mismatch;
   logic            fault_hit;
   logic            accept;
   logic            trip;

   // Local copy comparison catches a stuck-at-good upstream flag.
   always_comb begin
      mismatch = 1'b0;
      for (int i = 1; i < COPIES; i++) begin
         if (bus.port_c[i*WIDTH +: WIDTH] != bus.port_c[0 +: WIDTH]) begin
            mismatch = 1'b1;
         end
      end
   end

   assign fault_hit      = ~bus.port_ok | mismatch;
   assign bus.port_ready = (state_q == ST_RUN) & (~valid_q | bus.port_ready_out);
   assign accept         = bus.port_valid_in & bus.port_ready;
   assign cnt_d          = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
   assign trip           = fault_hit & (cnt_d == THR);

   always_ff @(posedge port_clk or posedge port_rst) begin
      if (port_rst) begin
         state_q <= ST_RUN;
         data_q  <= '0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
         cnt_q   <= 4'd0;
      end else if (state_q == ST_ALARM) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else if (accept) begin
         if (fault_hit) begin
            cnt_q <= cnt_d;
         end
         // The tripping beat is dropped in the same edge that raises the alarm.
         if (trip) begin
            state_q <= ST_ALARM;
            data_q  <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
         end else begin
            data_q  <= fault_hit ? '0 : bus.port_c;
            valid_q <= 1'b1;
            fault_q <= fault_hit;
         end
      end else if (bus.port_ready_out) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.port_d         = data_q;
   assign bus.port_valid_out = valid_q;
   assign bus.port_fault     = fault_q;
   assign bus.port_alarm     = (state_q == ST_ALARM);
   assign bus.port_fault_cnt = cnt_q;

endmodule

`default_nettype wire

// File: doc/fini_fault_response.md
Name: fini_fault_response

Overview:
- Registered fault-response stage directly downstream of the replicated finite-field multiplier with concurrent error detection.
- Captures the COPIES redundant product copies and the upstream consistency flag, and re-checks copy agreement locally. This guards against a faulted flag.
- On a detected fault, forwards all-zero copies instead of the product. Counts faults and escalates to a sticky alarm state that blocks further traffic.

Parameters:
- WIDTH, 1, bits per product copy.
- COPIES, 3, number of redundant copies (k+1 for detection order k).
- THRESHOLD, 1, number of faults that triggers ALARM; legal range 1..15.

Ports:
- port_clk  input  1  clock; all state updates on rising edge.
- port_rst  input  1  asynchronous active-high reset.
- port_c  input  COPIES*WIDTH  product copies; copy i at bits [i*WIDTH +: WIDTH].
- port_ok  input  1  upstream consistency flag; 1 = copies agree.
- port_valid_in  input  1  port_c/port_ok valid this cycle.
- port_ready  output  1  stage can accept input this cycle.
- port_d  output  COPIES*WIDTH  registered copies; all zero on a fault.
- port_valid_out  output  1  port_d valid.
- port_ready_out  input  1  downstream accepts port_d.
- port_fault  output  1  registered with port_d; 1 = this beat was a fault.
- port_alarm  output  1  sticky alarm.
- port_fault_cnt  output  4  saturating fault counter.

Behaviour:
- Reset (async assert, sync release): port_d=0, port_valid_out=0, port_fault=0, port_alarm=0, port_fault_cnt=0, FSM=RUN.
- Fault definition, evaluated on accept: fault = ~port_ok OR any copy i (1..COPIES-1) differs from copy 0.
- Both checks are always evaluated. port_ok=1 with mismatching copies is a fault. port_ok=0 with agreeing copies is a fault.
- Output buffer is a single entry. port_ready = (FSM==RUN) & (~port_valid_out | port_ready_out). This is a combinational path from port_ready_out.
- Accept = port_valid_in & port_ready. On accept, next cycle:
  - port_valid_out=1;
  - port_d = fault ? 0 : port_c;
  - port_fault = fault.
  - Latency is 1 cycle.
- Output is held stable while port_valid_out & ~port_ready_out.
- port_valid_out drops on port_ready_out unless a new beat is accepted in the same cycle. Back-to-back throughput is 1 beat/cycle.
- Counter: increments on each accepted fault beat and saturates at 15. No other event changes it except reset.
- FSM has two states:
  - RUN -> ALARM in the cycle after an accepted fault makes the counter reach THRESHOLD.
  - ALARM -> exits only on reset.
- In ALARM:
  - port_alarm=1, port_ready=0, port_valid_out=0, port_d=0, port_fault=0.
  - Any pending output beat is discarded.
  - The counter freezes.
- The faulty beat that triggers ALARM is never delivered. Its zeroed beat is discarded in the same edge that enters ALARM.
- With THRESHOLD>1, earlier faults are delivered as zeroed beats with port_fault=1.
- port_valid_in while port_ready=0 has no effect. Upstream must hold the beat.
- Reset asserted mid-transfer clears all state immediately. No beat survives reset.
- Data path has no combinational input-to-output path. Only port_ready depends combinationally on port_ready_out.

Test Plan (WIDTH=1, COPIES=3 unless stated):
- Reset, then port_c=3'b111, port_ok=1, port_valid_in=1, port_ready_out=1 -> next cycle port_d=3'b111, port_valid_out=1, port_fault=0, port_fault_cnt=0.
- THRESHOLD=3, port_c=3'b101, port_ok=1 (flag lies) -> port_d=3'b000, port_fault=1, port_fault_cnt=1, port_alarm=0.
- THRESHOLD=3, port_c=3'b000, port_ok=0 -> port_d=3'b000, port_fault=1, port_fault_cnt increments.
- Backpressure: port_ready_out=0 for 4 cycles after beat 3'b111 -> port_d held at 3'b111, port_ready=0. Release -> next beat accepted the same cycle, no bubble.
- THRESHOLD=1, single fault 3'b011 -> port_alarm=1 next cycle, port_valid_out=0, port_ready=0, port_fault_cnt=1. Further port_valid_in is ignored until port_rst.
- Stream of 20 faults with THRESHOLD=15 -> port_fault_cnt reaches 15 and ALARM is entered. Assert port_rst asynchronously mid-cycle -> all outputs 0 immediately.
